// File: rtl/scan_mux_n_if.sv
// scan_mux_n_if -- signal bundle for the registered N-channel selector.
//
// Carries the channel data, the addressing/mode controls and the registered
// results. Clock and reset stay outside the bundle as plain ports.
//
//   I      W*NUM  channel data, channel k on bits [k*W +: W]
//   SEL    SEL_W  channel address used in direct mode
//   CE_N   1      enable, active-low
//   SCAN   1      1 = scan mode, 0 = direct mode
//   STEP   1      advance request, scan mode only
//   Q      W      registered selected data
//   Q_N    W      bitwise complement of Q
//   CH     SEL_W  channel index that produced Q
//   VALID  1      Q was freshly captured on the last edge
//   WRAP   1      last capture was channel NUM-1 in scan mode
//
// master: the side that drives data/controls; slave: the selector itself.
interface scan_mux_n_if #(
    parameter int W     = 1,
    parameter int SEL_W = 3,
    parameter int NUM   = 8
) ();
    logic [W*NUM-1:0] I;
    logic [SEL_W-1:0] SEL;
    logic             CE_N;
    logic             SCAN;
    logic             STEP;
    logic [W-1:0]     Q;
    logic [W-1:0]     Q_N;
    logic [SEL_W-1:0] CH;
    logic             VALID;
    logic             WRAP;

    modport master (
        output I, SEL, CE_N, SCAN, STEP,
        input  Q, Q_N, CH, VALID, WRAP
    );

    modport slave (
        input  I, SEL, CE_N, SCAN, STEP,
        output Q, Q_N, CH, VALID, WRAP
    );
endinterface

// File: rtl/scan_mux_n.sv
// scan_mux_n -- parametrised, registered N-channel, W-bit selector.
//
// Direct mode picks the channel addressed by SEL; scan mode walks an internal
// pointer round-robin through channels 0..NUM-1, one channel per STEP. The
// result is registered together with a valid strobe, the channel tag and a
// one-cycle wrap pulse marking the capture of the last channel.
//
// Ports:
//   CLK    rising-edge clock for all state
//   CLR_N  asynchronous active-low reset (clears outputs and scan pointer)
//   bus    scan_mux_n_if.slave: I, SEL, CE_N, SCAN, STEP in;
//          Q, Q_N, CH, VALID, WRAP out
//
// Parameters: W data width, SEL_W select/pointer width,
//             NUM active channels (2 <= NUM <= 2**SEL_W).
module scan_mux_n #(
    parameter int W     = 1,
    parameter int SEL_W = 3,
    parameter int NUM   = 8
) (
    input  logic         CLK,
    input  logic         CLR_N,
    scan_mux_n_if.slave  bus
);

    localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM - 1);
    // One extra bit so the range check still works when NUM == 2**SEL_W.
    localparam logic [SEL_W:0]   NUM_X = (SEL_W + 1)'(NUM);

    logic [W-1:0]     q_q, q_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;

    // Channel mux written as a compare loop so an address past NUM-1 never
    // produces an out-of-range part-select; it simply yields zero.
    function automatic logic [W-1:0] pick(input logic [W*NUM-1:0] d,
                                          input logic [SEL_W-1:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM; k++) begin
            if (s == SEL_W'(k)) r = d[k*W +: W];
        end
        return r;
    endfunction

    always_comb begin
        q_d    = q_q;
        ch_d   = ch_q;
        ptr_d  = ptr_q;
        vld_d  = 1'b0;
        wrap_d = 1'b0;

        if (bus.CE_N) begin
            // Disabled: output forced low, tag and scan position preserved.
            q_d = '0;
        end else if (!bus.SCAN) begin
            // Direct capture; pointer cleared so a later scan starts at 0.
            ch_d  = bus.SEL;
            ptr_d = '0;
            if ({1'b0, bus.SEL} < NUM_X) begin
                q_d   = pick(bus.I, bus.SEL);
                vld_d = 1'b1;
            end else begin
                q_d = '0;
            end
        end else if (bus.STEP) begin
            q_d   = pick(bus.I, ptr_q);
            ch_d  = ptr_q;
            vld_d = 1'b1;
            if (ptr_q == LAST) begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
        // Scan with STEP low: data, tag and pointer hold; strobes drop.
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            q_q    <= '0;
            ch_q   <= '0;
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            ch_q   <= ch_d;
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.Q_N   = ~q_q;
    assign bus.CH    = ch_q;
    assign bus.VALID = vld_q;
    assign bus.WRAP  = wrap_q;

endmodule
